display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed 7-segment digits, legal range 2..16.
REQ-002 Parameter CLK_DIV, default 1000: clock cycles per digit slot, minimum 2.
REQ-003 Parameter BLINK_SLOTS, default 256: digit slots per blink half-period.
REQ-004 Parameter LZB, default 1: leading-zero blanking in number mode is enabled when 1.
REQ-005 Define DPW = clog2(DIGITS).
REQ-006 Port clock, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high.
REQ-008 Port latch, input, 1 bit: load enable for mode/dp/codes/num.
REQ-009 Port mode, input, 1 bit: 0 = number mode, 1 = code mode.
REQ-010 Port dp, input, DPW bits: decimal-point digit index; 0 = LSD, DIGITS-1 = MSD.
REQ-011 Port codes, input, 4 bits: bit 3 = blink enable, bits 2:0 = message select.
REQ-012 Port num, input, 4*DIGITS bits: BCD digits, nibble i = digit i, nibble 0 = LSD.
REQ-013 Port seg_n, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-014 Port dp_n, output, 1 bit: decimal-point segment, active-low.
REQ-015 Port an_n, output, DIGITS bits: digit enables, one-hot active-low.
REQ-016 Port slot_tick, output, 1 bit: one-cycle pulse on each digit-slot advance.

Function
REQ-017 A rising edge of clock with latch=1 SHALL capture mode, dp, codes and num into shadow registers; with latch=0 the shadows hold.
REQ-018 Display content SHALL derive only from the shadows; unlatched input changes have no visible effect.
REQ-019 Prescaler: counts 0..CLK_DIV-1 and wraps to 0; slot_tick = 1 for exactly the cycle in which it wraps.
REQ-020 On each slot_tick the digit index SHALL advance i -> i+1, with DIGITS-1 wrapping to 0.
REQ-021 Blink counter: advances on each slot_tick, wraps at BLINK_SLOTS-1, and toggles blink phase on wrap; phase 0 = visible.
REQ-022 Outputs SHALL be registered and reflect the digit index and shadows with a latency of 1 clock.
REQ-023 an_n SHALL have exactly one bit low, at the current index.
REQ-024 Number mode BCD decode (active-high, a = bit 0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; nibbles A..F decode blank.
REQ-025 Number mode: dp_n = 0 iff index == shadow dp.
REQ-026 With LZB=1, digit i SHALL be blanked iff all of the following hold: i > shadow dp, i > 0, and nibbles DIGITS-1..i are all zero.
REQ-027 A blanked digit SHALL drive seg_n = all 1 and dp_n = 1, with an_n still active.
REQ-028 Code mode, codes[2:0]=0: all digits blank.
REQ-029 Code mode, codes[2:0]=1: "Err" right-aligned, r=50 on digits 0 and 1, E=79 on digit 2, others blank.
REQ-030 Code mode, codes[2:0]=2: "-" (40) on every digit.
REQ-031 Code mode, codes[2:0]=3: "8." on every digit (lamp test, dp_n = 0).
REQ-032 Code mode, codes[2:0]=4..7: reserved, all blank; in code mode dp_n = 1 except code 3.
REQ-033 Code mode with codes[3]=1 and blink phase 1: seg_n and dp_n all 1; an_n keeps scanning.
REQ-034 Latch asserted in the same cycle as slot_tick: the new index SHALL display the newly latched data.
REQ-035 A dp value >= DIGITS SHALL place no decimal point and be treated as 0 for LZB.

Reset
REQ-036 Asserting reset SHALL immediately clear prescaler, index, blink counter, blink phase and all shadows to 0, independent of clock.
REQ-037 While reset=1: seg_n all 1, dp_n 1, an_n all 1, slot_tick 0.
REQ-038 Following reset deassertion, the first rising edge drives an_n bit 0 low and displays "0." on digit 0 with the other digits blanked.
REQ-039 Reset mid-slot or mid-blink SHALL restart scan and blink from 0 with no partial pulse.

Verification (DIGITS=4, CLK_DIV=4, BLINK_SLOTS=2)
REQ-040 Reset release, no latch -> an_n cycles E,D,B,7 each 4 clocks; digit 0 seg_n=40, dp_n=0; digits 1-3 all blank.
REQ-041 latch, mode=0, num=16'h0305, dp=1 -> digit3 blank, digit2 seg_n=30, digit1 seg_n=40 with dp_n=0, digit0 seg_n=12.
REQ-042 latch, mode=1, codes=4'h1 -> digits0-1 seg_n=2F, digit2 seg_n=06, digit3 blank.
REQ-043 codes=4'h9 latched -> "Err" visible for 2 slots, blank for 2 slots, repeating; an_n never all 1.
REQ-044 num changed with latch=0 -> no display change; reset pulsed mid-slot -> outputs all 1 in the same cycle, scan restarts at digit 0.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: multiplexed 7-segment scanner with shadowed content,
// BCD number mode with leading-zero blanking, and canned message codes.
module display_scan #(
    parameter int DIGITS      = 8,
    parameter int CLK_DIV     = 1000,
    parameter int BLINK_SLOTS = 256,
    parameter int LZB         = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      latch,
    input  logic                      mode,
    input  logic [$clog2(DIGITS)-1:0] dp,
    input  logic [3:0]                codes,
    input  logic [4*DIGITS-1:0]       num,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [DIGITS-1:0]         an_n,
    output logic                      slot_tick
);

    localparam int DPW = $clog2(DIGITS);
    localparam int PW  = $clog2(CLK_DIV);
    localparam int BW  = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    localparam logic [2:0] MSG_BLANK = 3'd0;
    localparam logic [2:0] MSG_ERR   = 3'd1;
    localparam logic [2:0] MSG_DASH  = 3'd2;
    localparam logic [2:0] MSG_LAMP  = 3'd3;

    localparam logic [6:0] SEG_R    = 7'h50;
    localparam logic [6:0] SEG_E    = 7'h79;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_ALL  = 7'h7F;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    logic [PW-1:0]       presc;
    logic [DPW-1:0]      idx;
    logic [BW-1:0]       blk;
    logic                phase;

    logic                sh_mode;
    logic [DPW-1:0]      sh_dp;
    logic [3:0]          sh_codes;
    logic [4*DIGITS-1:0] sh_num;

    logic                tick;
    logic                dp_ok;
    logic [DPW-1:0]      dp_eff;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   zhi;
    logic                blank_lz;
    logic [6:0]          seg_d;
    logic                dpon;

    // BCD digit to active-high segments; A..F show nothing
    function automatic logic [6:0] bcd7(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_OFF;
        case (v)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    assign tick      = (presc == PW'(CLK_DIV - 1));
    assign slot_tick = tick;

    // an out-of-range dp shows no point and acts as digit 0 for blanking
    assign dp_ok  = (32'(sh_dp) < DIGITS);
    assign dp_eff = dp_ok ? sh_dp : '0;
    assign nib    = sh_num[{idx, 2'b00} +: 4];

    // zhi[i]: every nibble from i up to the MSD is zero
    always_comb begin
        zhi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            zhi[i] = ~|(sh_num >> (4 * i));
        end
    end

    assign blank_lz = (LZB != 0) && (idx > dp_eff) &&
                      (idx != '0) && zhi[idx];

    // content of the current digit, active-high, before output register
    always_comb begin
        seg_d = SEG_OFF;
        dpon  = 1'b0;
        if (!sh_mode) begin
            if (!blank_lz) begin
                seg_d = bcd7(nib);
                dpon  = dp_ok && (idx == sh_dp);
            end
        end else begin
            case (sh_codes[2:0])
                MSG_BLANK: seg_d = SEG_OFF;
                MSG_ERR: begin
                    if (32'(idx) < 2) begin
                        seg_d = SEG_R;
                    end else if (32'(idx) == 2) begin
                        seg_d = SEG_E;
                    end
                end
                MSG_DASH: seg_d = SEG_DASH;
                MSG_LAMP: begin
                    seg_d = SEG_ALL;
                    dpon  = 1'b1;
                end
                default: seg_d = SEG_OFF;
            endcase
            if (sh_codes[3] && phase) begin
                seg_d = SEG_OFF;
                dpon  = 1'b0;
            end
        end
    end

    // slot prescaler
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // digit index advances once per slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == DPW'(DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // blink half-period counter and phase
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk   <= '0;
            phase <= 1'b0;
        end else if (tick) begin
            if (blk == BW'(BLINK_SLOTS - 1)) begin
                blk   <= '0;
                phase <= ~phase;
            end else begin
                blk <= blk + 1'b1;
            end
        end
    end

    // shadow copy of the display content
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_mode  <= 1'b0;
            sh_dp    <= '0;
            sh_codes <= '0;
            sh_num   <= '0;
        end else if (latch) begin
            sh_mode  <= mode;
            sh_dp    <= dp;
            sh_codes <= codes;
            sh_num   <= num;
        end
    end

    // registered active-low drive of the pins
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_n <= '1;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= ~seg_d;
            dp_n  <= ~dpon;
            an_n  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of display_scan with 4 digits,
// 4 clocks per slot and 2 slots per blink half-period.
module tb_display_scan;

    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 4;
    localparam int BLINK_SLOTS = 2;

    localparam logic [27:0] T_DEF  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] T_0305 = {7'h7F, 7'h30, 7'h40, 7'h12};
    localparam logic [27:0] T_0089 = {7'h40, 7'h40, 7'h00, 7'h10};
    localparam logic [27:0] T_1000 = {7'h79, 7'h40, 7'h40, 7'h40};
    localparam logic [27:0] T_ERR  = {7'h7F, 7'h06, 7'h2F, 7'h2F};
    localparam logic [27:0] T_DASH = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [27:0] T_LAMP = {7'h00, 7'h00, 7'h00, 7'h00};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        latch = 1'b0;
    logic        mode  = 1'b0;
    logic [1:0]  dp    = 2'd0;
    logic [3:0]  codes = 4'd0;
    logic [15:0] num   = 16'd0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        slot_tick;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;

    display_scan #(
        .DIGITS     (DIGITS),
        .CLK_DIV    (CLK_DIV),
        .BLINK_SLOTS(BLINK_SLOTS),
        .LZB        (1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .latch    (latch),
        .mode     (mode),
        .dp       (dp),
        .codes    (codes),
        .num      (num),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .slot_tick(slot_tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        k++;
        @(negedge clock);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/seg"}, 32'(seg_n), 32'h7F);
        chk({tag, "/dp"}, 32'(dp_n), 32'h1);
        chk({tag, "/an"}, 32'(an_n), 32'hF);
        chk({tag, "/tick"}, 32'(slot_tick), 32'h0);
    endtask

    // output after edge k shows the state left by edge k-1
    task automatic scan(input int n, input string tag,
                        input logic [27:0] es, input logic [3:0] ed,
                        input logic bl);
        int         d;
        logic       ph;
        logic [3:0] ea;
        logic [6:0] eseg;
        logic       edp;
        for (int c = 0; c < n; c++) begin
            adv();
            d  = ((k - 1) / 4) % 4;
            ph = (((k - 1) / 8) % 2) == 1;
            ea = ~(4'b0001 << d);
            if (bl && ph) begin
                eseg = 7'h7F;
                edp  = 1'b1;
            end else begin
                eseg = es[7*d +: 7];
                edp  = ed[d];
            end
            chk($sformatf("%s/an k%0d", tag, k), 32'(an_n), 32'(ea));
            chk($sformatf("%s/seg d%0d k%0d", tag, d, k),
                32'(seg_n), 32'(eseg));
            chk($sformatf("%s/dp d%0d k%0d", tag, d, k),
                32'(dp_n), 32'(edp));
            chk($sformatf("%s/tick k%0d", tag, k),
                32'(slot_tick), 32'((k % 4) == 3));
        end
    endtask

    task automatic load(input logic m, input logic [1:0] p,
                        input logic [3:0] c, input logic [15:0] v);
        mode  = m;
        dp    = p;
        codes = c;
        num   = v;
        latch = 1'b1;
        adv();
        latch = 1'b0;
    endtask

    initial begin
        logic found;

        @(negedge clock);
        chk_idle("rst");
        reset = 1'b0;
        k     = 0;
        scan(20, "boot", T_DEF, 4'b1110, 1'b0);

        load(1'b0, 2'd1, 4'h0, 16'h0305);
        scan(16, "n0305", T_0305, 4'b1101, 1'b0);

        num = 16'h9999;
        dp  = 2'd3;
        scan(16, "nolatch", T_0305, 4'b1101, 1'b0);

        load(1'b0, 2'd3, 4'h0, 16'h0089);
        scan(16, "n0089", T_0089, 4'b0111, 1'b0);

        load(1'b0, 2'd0, 4'h0, 16'h00A0);
        scan(16, "n00A0", T_DEF, 4'b1110, 1'b0);

        load(1'b0, 2'd0, 4'h0, 16'h1000);
        scan(16, "n1000", T_1000, 4'b1110, 1'b0);

        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (slot_tick) begin
                found = 1'b1;
            end else begin
                adv();
            end
        end
        chk("tickwait", 32'(found), 32'h1);
        load(1'b1, 2'd0, 4'h1, 16'h1000);
        scan(16, "err", T_ERR, 4'b1111, 1'b0);

        load(1'b1, 2'd0, 4'h2, 16'h1000);
        scan(16, "dash", T_DASH, 4'b1111, 1'b0);

        load(1'b1, 2'd0, 4'h3, 16'h1000);
        scan(16, "lamp", T_LAMP, 4'b0000, 1'b0);

        load(1'b1, 2'd0, 4'h5, 16'h1000);
        scan(16, "resv", {4{7'h7F}}, 4'b1111, 1'b0);

        load(1'b1, 2'd0, 4'h9, 16'h1000);
        scan(40, "blink", T_ERR, 4'b1111, 1'b1);

        adv();
        adv();
        #2;
        reset = 1'b1;
        #1;
        chk_idle("rst2");
        @(negedge clock);
        chk_idle("rst2h");
        reset = 1'b0;
        k     = 0;
        scan(20, "reboot", T_DEF, 4'b1110, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
